// File: rtl/inv_arbiter_2x2.sv
// inv_arbiter_2x2: round-robin arbiter and sequencer that shares one 2x2
// matrix inverter between N_REQ channels. It latches the granted channel's
// operand, runs the inverter's startInv/endInv handshake, and returns the
// captured result with a one-cycle done pulse to the owning channel.
// Optional feature: define INV_ARB_TIMEOUT_EN to add a RUN-state watchdog
// that aborts after TIMEOUT cycles with a zeroed result and an err pulse.
module inv_arbiter_2x2 #(
    parameter int WIDTH   = 16,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [N_REQ-1:0]                        req,
    input  logic [0:N_REQ-1][0:1][0:1][WIDTH-1:0]   req_A,
    output logic [N_REQ-1:0]                        grant,
    output logic [N_REQ-1:0]                        done,
    output logic [0:1][0:1][WIDTH-1:0]              res,
    output logic                                    err,
    output logic                                    busy,
    output logic                                    inv_start,
    output logic [0:1][0:1][WIDTH-1:0]              inv_A,
    input  logic [0:1][0:1][WIDTH-1:0]              inv_Res,
    input  logic                                    inv_end
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        CAPTURE = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                         state_q;
    logic [IDX_W-1:0]               ptr_q;
    logic [IDX_W-1:0]               owner_q;
    logic [N_REQ-1:0]               grant_q;
    logic [N_REQ-1:0]               done_q;
    logic [0:1][0:1][WIDTH-1:0]     res_q;
    logic [0:1][0:1][WIDTH-1:0]     inv_A_q;
    logic                           inv_start_q;

    logic                           found_d;
    logic [IDX_W-1:0]               sel_d;

    // Channel index base+off, wrapped into 0..N_REQ-1.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return s[IDX_W-1:0];
    endfunction

    // Round-robin successor of the channel just served.
    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] o);
        if (int'(o) == N_REQ - 1) return '0;
        return o + IDX_W'(1);
    endfunction

`ifdef INV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    // First pending request at or above ptr, wrapping around.
    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found_d && req[wrap_idx(ptr_q, i)]) begin
                found_d = 1'b1;
                sel_d   = wrap_idx(ptr_q, i);
            end
        end
    end

    // Sequencer FSM with registered grant/done/result/operand/start outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            res_q       <= '0;
            inv_A_q     <= '0;
            inv_start_q <= 1'b0;
`ifdef INV_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            done_q <= '0;
`ifdef INV_ARB_TIMEOUT_EN
            err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        owner_q        <= sel_d;
                        grant_q        <= '0;
                        grant_q[sel_d] <= 1'b1;
                        state_q        <= LOAD;
                    end
                end
                LOAD: begin
                    // Operand is sampled only here; the channel may change it afterwards.
                    inv_A_q     <= req_A[owner_q];
                    inv_start_q <= 1'b1;
`ifdef INV_ARB_TIMEOUT_EN
                    cnt_q       <= '0;
`endif
                    state_q     <= RUN;
                end
                RUN: begin
                    if (inv_end) begin
                        res_q           <= inv_Res;
                        done_q[owner_q] <= 1'b1;
                        inv_start_q     <= 1'b0;
                        grant_q         <= '0;
                        ptr_q           <= next_ptr(owner_q);
                        state_q         <= CAPTURE;
                    end
`ifdef INV_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        // Inverter never answered: abort with a zero result.
                        res_q           <= '0;
                        done_q[owner_q] <= 1'b1;
                        err_q           <= 1'b1;
                        inv_start_q     <= 1'b0;
                        grant_q         <= '0;
                        ptr_q           <= next_ptr(owner_q);
                        state_q         <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                CAPTURE: begin
                    // done is visible this cycle; a still-high inv_end must clear first.
                    state_q <= inv_end ? RELEASE : IDLE;
                end
                RELEASE: begin
                    if (!inv_end) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign res       = res_q;
    assign busy      = (state_q != IDLE);
    assign inv_start = inv_start_q;
    assign inv_A     = inv_A_q;

endmodule

// File: tb/tb_inv_arbiter_2x2.sv
// Self-checking bench for inv_arbiter_2x2 with a behavioural inverter model
// (adjugate response, configurable latency and inv_end hold) and a
// round-robin reference model working on request sets.
module tb_inv_arbiter_2x2;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int TO = 64;

    typedef logic [0:1][0:1][W-1:0] mat_t;

    logic                           clk = 1'b0;
    logic                           rst_n;
    logic [N-1:0]                   req;
    logic [0:N-1][0:1][0:1][W-1:0]  req_A;
    logic [N-1:0]                   grant;
    logic [N-1:0]                   done;
    mat_t                           res;
    logic                           err;
    logic                           busy;
    logic                           inv_start;
    mat_t                           inv_A;
    mat_t                           inv_Res = '0;
    logic                           inv_end = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int cur_delay = 1;
    int cur_hold = 0;
    bit cur_never = 1'b0;
    int scnt = 0;
    int hcnt = 0;
    int ref_ptr = 0;

    inv_arbiter_2x2 #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_A(req_A),
        .grant(grant), .done(done), .res(res), .err(err), .busy(busy),
        .inv_start(inv_start), .inv_A(inv_A), .inv_Res(inv_Res), .inv_end(inv_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                m[i][j] = W'($urandom);
        return m;
    endfunction

    // Adjugate: what the inverter model returns, and what res must show.
    function automatic mat_t adj(input mat_t a);
        mat_t r;
        r[0][0] = a[1][1];
        r[0][1] = -a[0][1];
        r[1][0] = -a[1][0];
        r[1][1] = a[0][0];
        return r;
    endfunction

    // Round-robin rule: first pending channel at or after ptr, wrapping.
    function automatic int ref_pick(input logic [N-1:0] pend, input int ptr);
        for (int i = 0; i < N; i++)
            if (pend[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    // Inverter model: inv_end rises cur_delay cycles after inv_start, and
    // stays high cur_hold cycles after inv_start falls.
    always @(negedge clk) begin
        if (inv_start) begin
            hcnt <= 0;
            scnt <= scnt + 1;
            if (!cur_never && scnt == cur_delay) begin
                inv_end <= 1'b1;
                inv_Res <= adj(inv_A);
            end
        end else begin
            scnt <= 0;
            if (inv_end) begin
                hcnt <= hcnt + 1;
                if (hcnt >= cur_hold) begin
                    inv_end <= 1'b0;
                    inv_Res <= rand_mat();
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        ref_ptr = 0;
    endtask

    // Observe one complete operation for channel ch and check every phase.
    task automatic serve_one(input int ch, input int dly, input int hold, input bit never,
                             input bit drop_run, input int exp_load, output int next_load);
        mat_t expA, expR;
        int L, D, w, exp_D;
        bit ok;
        logic [N-1:0] oh;
        oh = {{(N-1){1'b0}}, 1'b1} << ch;
        cur_delay = dly;
        cur_hold  = hold;
        cur_never = never;
        w = 0;
        while (grant === '0 && w < 100) begin
            @(posedge clk); #1; w++;
        end
        L = cyc;
        expA = req_A[ch];
        n_cmp++; if (grant !== oh) begin n_fail++; $display("FAIL grant: got %b expected %b", grant, oh); end
        n_cmp++; if (L !== exp_load) begin n_fail++; $display("FAIL load_cycle: got %0d expected %0d", L, exp_load); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_load: got %b expected 1", busy); end
        @(posedge clk); #1;
        req_A[ch] = rand_mat();
        if (drop_run) req[ch] = 1'b0;
        n_cmp++; if (inv_start !== 1'b1) begin n_fail++; $display("FAIL inv_start_rise: got %b expected 1", inv_start); end
        n_cmp++; if (inv_A !== expA) begin n_fail++; $display("FAIL inv_A: got %h expected %h", inv_A, expA); end
        ok = 1'b1;
        w = 0;
        while (done === '0 && w < 200) begin
            if (inv_start !== 1'b1) ok = 1'b0;
            @(posedge clk); #1; w++;
        end
        D = cyc;
        exp_D = never ? (L + 1 + TO) : (L + 2 + dly);
        expR  = never ? '0 : adj(expA);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL inv_start_held: got %b expected 1", ok); end
        n_cmp++; if (D !== exp_D) begin n_fail++; $display("FAIL done_cycle: got %0d expected %0d", D, exp_D); end
        n_cmp++; if (done !== oh) begin n_fail++; $display("FAIL done: got %b expected %b", done, oh); end
        n_cmp++; if (res !== expR) begin n_fail++; $display("FAIL res: got %h expected %h", res, expR); end
        n_cmp++; if (err !== never) begin n_fail++; $display("FAIL err: got %b expected %b", err, never); end
        n_cmp++; if (inv_start !== 1'b0 || grant !== '0) begin
            n_fail++; $display("FAIL capture_outputs: got start=%b grant=%b expected 0/0", inv_start, grant);
        end
        req[ch] = 1'b0;
        ok = 1'b1;
        for (int j = 1; j <= hold; j++) begin
            @(posedge clk); #1;
            if (done !== '0 || inv_start !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL release_hold: got %b expected 1", ok); end
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || done !== '0 || inv_start !== 1'b0) begin
            n_fail++; $display("FAIL idle_return: got busy=%b done=%b start=%b expected 0/0/0", busy, done, inv_start);
        end
        next_load = D + hold + 2;
    endtask

    // Raise a request set and serve it to completion in reference order.
    task automatic serve_mask(input logic [N-1:0] mask, input int drop_ch, input int fixed_hold);
        logic [N-1:0] pending;
        int ch, nl, dly, hold;
        pending = mask;
        for (int c = 0; c < N; c++) if (mask[c]) req_A[c] = rand_mat();
        req = mask;
        nl = cyc + 1;
        while (pending != '0) begin
            ch   = ref_pick(pending, ref_ptr);
            dly  = $urandom_range(1, 6);
            hold = (fixed_hold >= 0) ? fixed_hold : $urandom_range(0, 3);
            serve_one(ch, dly, hold, 1'b0, (ch == drop_ch), nl, nl);
            pending[ch] = 1'b0;
            ref_ptr = (ch + 1) % N;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '1;
        for (int c = 0; c < N; c++) req_A[c] = rand_mat();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (grant !== '0) begin n_fail++; $display("FAIL rst_grant: got %b expected 0", grant); end
        n_cmp++; if (done !== '0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_cmp++; if (res !== '0) begin n_fail++; $display("FAIL rst_res: got %h expected 0", res); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_cmp++; if (inv_start !== 1'b0) begin n_fail++; $display("FAIL rst_inv_start: got %b expected 0", inv_start); end
        n_cmp++; if (inv_A !== '0) begin n_fail++; $display("FAIL rst_inv_A: got %h expected 0", inv_A); end
        req   = '0;
        rst_n = 1'b1;
        ref_ptr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int nl;
        mat_t want;
        want = {16'd6, -16'd23, -16'd2, 16'd8};
        req_A[0] = {16'd8, 16'd23, 16'd2, 16'd6};
        req = 4'b0001;
        serve_one(0, 5, 0, 1'b0, 1'b0, cyc + 1, nl);
        ref_ptr = 1;
        n_cmp++; if (res !== want) begin n_fail++; $display("FAIL single_res: got %h expected %h", res, want); end
    endtask

    task automatic test_round_robin();
        do_reset();
        serve_mask(4'b1111, -1, -1);
        serve_mask(4'b0010, -1, 0);
        serve_mask(4'b1011, -1, -1);
    endtask

    task automatic test_level_end();
        serve_mask(4'b0100, -1, 3);
    endtask

    task automatic test_drop_run();
        serve_mask(4'b0010, 1, -1);
    endtask

    task automatic test_random();
        logic [N-1:0] m;
        for (int it = 0; it < 6; it++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            serve_mask(m, -1, -1);
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        cur_delay = 30;
        cur_hold  = 0;
        cur_never = 1'b0;
        req_A[2] = rand_mat();
        req = 4'b0100;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (inv_start !== 1'b1) begin n_fail++; $display("FAIL arst_pre_start: got %b expected 1", inv_start); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (inv_start !== 1'b0) begin n_fail++; $display("FAIL arst_inv_start: got %b expected 0", inv_start); end
        n_cmp++; if (grant !== '0) begin n_fail++; $display("FAIL arst_grant: got %b expected 0", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b expected 0", busy); end
        req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_ptr = 0;
        ok = 1'b1;
        for (int j = 0; j < 40; j++) begin
            @(posedge clk); #1;
            if (done !== '0 || inv_start !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL arst_no_done: got %b expected 1", ok); end
    endtask

`ifdef INV_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        int nl;
        int first;
        req_A[0] = rand_mat();
        req_A[1] = rand_mat();
        req = 4'b0011;
        first = ref_pick(4'b0011, ref_ptr);
        serve_one(first, 0, 0, 1'b1, 1'b0, cyc + 1, nl);
        ref_ptr = (first + 1) % N;
        serve_one(ref_pick(4'b0011 & ~(4'b0001 << first), ref_ptr), 3, 0, 1'b0, 1'b0, nl, nl);
    endtask
`endif

    initial begin
        req   = '0;
        req_A = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_level_end();
        test_drop_run();
        test_random();
        test_async_reset();
`ifdef INV_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish within budget");
        $fatal(1, "simulation time budget exceeded");
    end

endmodule
